s_axi_regfile: RTL and testbench

//  Parametrised AXI slave register file: NUM_REGS x DATA_W registers with byte strobes,

---
 rtl/s_axi_regfile.sv | 141 ++++++++++++++
 tb/tb_s_axi_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/s_axi_regfile.sv
// s_axi_regfile: AXI slave register bank of NUM_REGS x DATA_W registers with byte strobes.
// It captures AW and W independently and answers with ID-tagged single-beat B and R responses.
// Reads have one cycle of latency.
// Optional macro S_AXI_REGFILE_SLVERR_EN makes out-of-range indices return SLVERR.
// When that macro is not defined, addresses alias modulo NUM_REGS.
module s_axi_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready_i
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int HI     = OFF_W + IDX_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              has_addr_q, has_data_q, aw_err_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [ID_W-1:0]   awid_q, bid_q, rid_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic              aw_hs, w_hs, ar_hs, commit, aw_err, ar_err;
    logic [IDX_W-1:0]  ar_idx;
    logic              unused_ok;

    assign awready_o = areset && !has_addr_q;
    assign wready_o  = areset && !has_data_q;
    assign arready_o = areset && (!rvalid_q || rready_i);
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;
    assign ar_hs     = arvalid_i && arready_o;
    assign commit    = has_addr_q && has_data_q && (!bvalid_q || bready_i);
    assign ar_idx    = araddr_i[OFF_W +: IDX_W];
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign bvalid_o  = bvalid_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rvalid_q;
`ifdef S_AXI_REGFILE_SLVERR_EN
    assign aw_err = |awaddr_i[ADDR_W-1:HI];
    assign ar_err = |araddr_i[ADDR_W-1:HI];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif
    // Byte-offset bits and WLAST carry no information for single-beat register access.
    assign unused_ok = ^{wlast_i, awaddr_i, araddr_i};

    // Register array: strobed lane writes on commit; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit && !aw_err_q) begin
            for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b]) regs_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    // Channel state: AW/W holding slots, B response and registered R response.
    always_ff @(posedge clk) begin
        if (!areset) begin
            has_addr_q <= 1'b0;
            has_data_q <= 1'b0;
            aw_err_q   <= 1'b0;
            aw_idx_q   <= '0;
            awid_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            if (aw_hs) begin
                has_addr_q <= 1'b1;
                aw_idx_q   <= awaddr_i[OFF_W +: IDX_W];
                aw_err_q   <= aw_err;
                awid_q     <= awid_i;
            end else if (commit) begin
                has_addr_q <= 1'b0;
            end
            if (w_hs) begin
                has_data_q <= 1'b1;
                wdata_q    <= wdata_i;
                wstrb_q    <= wstrb_i;
            end else if (commit) begin
                has_data_q <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bid_q    <= awid_q;
                bresp_q  <= {aw_err_q, 1'b0};
            end else if (bready_i) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rid_q    <= arid_i;
                rdata_q  <= ar_err ? '0 : regs_q[ar_idx];
                rresp_q  <= {ar_err, 1'b0};
            end else if (rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_s_axi_regfile.sv
// tb_s_axi_regfile: directed bench for s_axi_regfile (default 32-bit, 8 registers).
module tb_s_axi_regfile;
    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [1:0]  bresp, rresp;
    int          n_cmp = 0;
    int          n_err = 0;

    s_axi_regfile dut (
        .clk(clk), .areset(areset),
        .awid_i(awid), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid),
        .rready_i(rready)
    );

    always #5 clk = ~clk;

`ifdef S_AXI_REGFILE_SLVERR_EN
    localparam logic [1:0]  ERR   = 2'b10;
    localparam logic [31:0] ALIAS0 = 32'h0;
    localparam logic [31:0] REG1  = 32'h11BB33DD;
`else
    localparam logic [1:0]  ERR   = 2'b00;
    localparam logic [31:0] ALIAS0 = 32'hCAFE0000;
    localparam logic [31:0] REG1  = 32'h12345678;
`endif

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] eb);
        awvalid = 1'b1; awaddr = a; awid = id;
        wvalid = 1'b1; wdata = d; wstrb = s;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("b_early", bvalid, 1'b0);
        tick;
        chk("b_valid", bvalid, 1'b1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, eb);
        tick;
        chk("b_clear", bvalid, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [31:0] ed,
                      input logic [1:0] er);
        arvalid = 1'b1; araddr = a; arid = id;
        tick;
        arvalid = 1'b0;
        chk("r_valid", rvalid, 1'b1);
        chk("r_data", rdata, ed);
        chk("r_id", rid, id);
        chk("r_resp", rresp, er);
        chk("r_last", rlast, 1'b1);
        tick;
    endtask

    initial begin
        areset = 1'b0; awid = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wlast = 1'b1; wvalid = 1'b0; bready = 1'b1; arid = '0; araddr = '0;
        arvalid = 1'b0; rready = 1'b1;
        tick; tick;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        areset = 1'b1;
        tick;
        chk("awready_idle", awready, 1'b1);
        chk("wready_idle", wready, 1'b1);
        chk("arready_idle", arready, 1'b1);
        // AW+W same cycle
        wr(32'h8, 4'd3, 32'hDEADBEEF, 4'hF, 2'b00);
        rd(32'h8, 4'd7, 32'hDEADBEEF, 2'b00);
        // W three cycles ahead of AW
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
        tick;
        wvalid = 1'b0;
        chk("w_held_ready", wready, 1'b0);
        tick; tick;
        chk("w_only_nob", bvalid, 1'b0);
        awvalid = 1'b1; awaddr = 32'h4; awid = 4'd5;
        tick;
        awvalid = 1'b0;
        chk("aw_late_nob", bvalid, 1'b0);
        tick;
        chk("aw_late_b", bvalid, 1'b1);
        chk("aw_late_bid", bid, 4'd5);
        tick;
        chk("aw_late_single", bvalid, 1'b0);
        rd(32'h4, 4'd1, 32'h11223344, 2'b00);
        wr(32'h4, 4'd6, 32'hAABBCCDD, 4'b0101, 2'b00);
        rd(32'h4, 4'd2, 32'h11BB33DD, 2'b00);
        // B backpressure with a second write queued behind it
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h10; awid = 4'd7; wvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        tick;
        chk("b1_valid", bvalid, 1'b1);
        chk("b1_id", bid, 4'd7);
        chk("aw2_ready", awready, 1'b1);
        awvalid = 1'b1; awaddr = 32'h14; awid = 4'd9; wvalid = 1'b1; wdata = 32'h2;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("b1_hold_id", bid, 4'd7);
        tick; tick;
        chk("b1_hold_valid", bvalid, 1'b1);
        chk("b1_hold_id2", bid, 4'd7);
        chk("aw2_stalled", awready, 1'b0);
        bready = 1'b1;
        tick;
        chk("b2_valid", bvalid, 1'b1);
        chk("b2_id", bid, 4'd9);
        tick;
        chk("b2_clear", bvalid, 1'b0);
        rd(32'h10, 4'd3, 32'h1, 2'b00);
        rd(32'h14, 4'd4, 32'h2, 2'b00);
        // Back-to-back reads
        arvalid = 1'b1; araddr = 32'h8; arid = 4'd1;
        tick;
        chk("bb1_valid", rvalid, 1'b1);
        chk("bb1_id", rid, 4'd1);
        chk("bb1_data", rdata, 32'hDEADBEEF);
        chk("bb1_last", rlast, 1'b1);
        araddr = 32'h4; arid = 4'd2;
        tick;
        chk("bb2_valid", rvalid, 1'b1);
        chk("bb2_id", rid, 4'd2);
        chk("bb2_data", rdata, 32'h11BB33DD);
        araddr = 32'h10; arid = 4'd3;
        tick;
        chk("bb3_valid", rvalid, 1'b1);
        chk("bb3_id", rid, 4'd3);
        chk("bb3_data", rdata, 32'h1);
        arvalid = 1'b0;
        tick;
        chk("bb_clear", rvalid, 1'b0);
        // R held under backpressure
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h14; arid = 4'd4;
        tick;
        arvalid = 1'b0;
        chk("rhold_arready", arready, 1'b0);
        tick; tick;
        chk("rhold_valid", rvalid, 1'b1);
        chk("rhold_id", rid, 4'd4);
        chk("rhold_data", rdata, 32'h2);
        rready = 1'b1;
        tick;
        chk("rhold_clear", rvalid, 1'b0);
        // Read and commit to the same register on one edge
        awvalid = 1'b1; awaddr = 32'h18; awid = 4'd2; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h18; arid = 4'd1;
        tick;
        arvalid = 1'b0;
        chk("rw_same_rdata", rdata, 32'h0);
        chk("rw_same_bvalid", bvalid, 1'b1);
        tick;
        rd(32'h18, 4'd5, 32'h55, 2'b00);
        // Zero strobe: response but no change
        wr(32'h8, 4'd2, 32'hFFFFFFFF, 4'h0, 2'b00);
        rd(32'h8, 4'd6, 32'hDEADBEEF, 2'b00);
        // Out-of-range index
        wr(32'h0, 4'd1, 32'hCAFE0000, 4'hF, 2'b00);
        rd(32'h40, 4'd8, ALIAS0, ERR);
        wr(32'h44, 4'd4, 32'h12345678, 4'hF, ERR);
        rd(32'h4, 4'd9, REG1, 2'b00);
        // Reset with B and R pending
        bready = 1'b0; rready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h1C; awid = 4'd6; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h8; arid = 4'd3;
        tick;
        arvalid = 1'b0;
        chk("pend_bvalid", bvalid, 1'b1);
        chk("pend_rvalid", rvalid, 1'b1);
        areset = 1'b0;
        tick;
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_bid", bid, 4'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_arready", arready, 1'b0);
        chk("mid_rst_awready", awready, 1'b0);
        areset = 1'b1; bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 8; i++) rd(32'(i * 4), 4'(i), 32'h0, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
